// File: rtl/isqrt_share_arbiter_pkg.sv
// Shared widths, defaults and requester-id type for the isqrt sharing arbiter.
package isqrt_arb_pkg;
    localparam int N_REQ_DEFAULT = 3;
    localparam int ARG_W         = 32;
    localparam int RES_W         = 16;
    localparam int REQ_ID_W      = $clog2(N_REQ_DEFAULT);

    typedef logic [REQ_ID_W-1:0] req_id_t;
endpackage

// File: rtl/isqrt_share_arbiter_if.sv
// Requester-side and isqrt-side handshake bundle; slave is the arbiter's view.
interface isqrt_share_arbiter_if
    import isqrt_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) ();
    logic [N_REQ-1:0]            req_x_vld;
    logic [N_REQ-1:0][ARG_W-1:0] req_x;
    logic [N_REQ-1:0]            req_y_vld;
    logic [N_REQ-1:0][RES_W-1:0] req_y;
    logic                        isqrt_x_vld;
    logic [ARG_W-1:0]            isqrt_x;
    logic                        isqrt_y_vld;
    logic [RES_W-1:0]            isqrt_y;
    logic                        err;

    modport slave (
        input  req_x_vld, req_x, isqrt_y_vld, isqrt_y,
        output req_y_vld, req_y, isqrt_x_vld, isqrt_x, err
    );

    modport master (
        output req_x_vld, req_x, isqrt_y_vld, isqrt_y,
        input  req_y_vld, req_y, isqrt_x_vld, isqrt_x, err
    );
endinterface

// File: rtl/isqrt_share_arbiter_tag_fifo.sv
// In-flight tag FIFO: remembers which requester owns each isqrt result, in issue order.
module isqrt_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/isqrt_share_arbiter.sv
// Shares one isqrt unit among N_REQ requesters: one-entry holding register each,
// round-robin issue, and in-order result routing via a tag FIFO.
module isqrt_share_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEFAULT,
    parameter int TAG_DEPTH = N_REQ
) (
    input logic                  clk,
    input logic                  rst,
    isqrt_share_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);
    typedef logic [ID_W-1:0] id_t;

    logic [N_REQ-1:0]            pend_q, pend_d, out_q, out_d;
    logic [N_REQ-1:0][ARG_W-1:0] arg_q, arg_d;
    logic [N_REQ-1:0]            req_y_vld_q, req_y_vld_d;
    logic [N_REQ-1:0][RES_W-1:0] req_y_q, req_y_d;
    id_t                         last_grant_q, last_grant_d;
    logic                        err_q, err_d;

    logic grant_vld, fifo_full, fifo_empty, resp_pop;
    id_t  grant_idx, cand, resp_tag;

    // Search starts one past the previous winner so every pending requester waits at most N_REQ cycles.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_grant_q;
        cand      = last_grant_q;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = id_t'((int'(last_grant_q) + k) % N_REQ);
            if (!grant_vld && pend_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (fifo_full) grant_vld = 1'b0;
    end

    assign resp_pop = bus.isqrt_y_vld && !fifo_empty;

    isqrt_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (grant_vld),
        .push_data_i (grant_idx),
        .pop_i       (resp_pop),
        .pop_data_o  (resp_tag),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Busy is judged on the registered pend/out, so a requester whose result pulses this cycle may re-request.
    always_comb begin
        pend_d       = pend_q;
        out_d        = out_q;
        arg_d        = arg_q;
        last_grant_d = last_grant_q;
        req_y_vld_d  = '0;
        req_y_d      = req_y_q;
        err_d        = err_q;

        if (resp_pop) begin
            req_y_vld_d[resp_tag] = 1'b1;
            req_y_d[resp_tag]     = bus.isqrt_y;
            out_d[resp_tag]       = 1'b0;
        end else if (bus.isqrt_y_vld) begin
            err_d = 1'b1;
        end

        if (grant_vld) begin
            pend_d[grant_idx] = 1'b0;
            out_d[grant_idx]  = 1'b1;
            last_grant_d      = grant_idx;
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_x_vld[i]) begin
                if (pend_q[i] || out_q[i]) begin
                    err_d = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    arg_d[i]  = bus.req_x[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q       <= '0;
            out_q        <= '0;
            arg_q        <= '0;
            req_y_vld_q  <= '0;
            req_y_q      <= '0;
            last_grant_q <= id_t'(N_REQ - 1);
            err_q        <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            out_q        <= out_d;
            arg_q        <= arg_d;
            req_y_vld_q  <= req_y_vld_d;
            req_y_q      <= req_y_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    assign bus.isqrt_x_vld = grant_vld;
    assign bus.isqrt_x     = arg_q[grant_idx];
    assign bus.req_y_vld   = req_y_vld_q;
    assign bus.req_y       = req_y_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_isqrt_share_arbiter.sv
// Bench for isqrt_share_arbiter: a fixed-latency isqrt stand-in, a per-cycle phase model, and directed scenarios.
module tb_isqrt_share_arbiter;
    import isqrt_arb_pkg::*;

    localparam int NR  = 3;
    localparam int LAT = 4;
    localparam int IDLE = 0, WAITING = 1, INFLIGHT = 2;

    typedef struct { int cycle; logic [31:0] x; } issue_t;
    typedef struct { int cycle; int idx; logic [15:0] y; } resp_t;
    typedef struct { int due; logic [15:0] y; } job_t;

    logic clk;
    logic rst;
    int   assertCount = 0;
    int   failCount   = 0;
    int   cyc         = 0;
    int   lastStimCycle;

    issue_t      issueLog[$];
    resp_t       respLog[$];
    job_t        jobQ[$];
    logic [2:0]  stimMask;
    logic [31:0] stimX[NR];
    bit          autoRe;
    bit          spurReq;

    isqrt_share_arbiter_if #(.N_REQ(NR)) bus ();

    isqrt_share_arbiter #(
        .N_REQ     (NR),
        .TAG_DEPTH (NR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] isqrtRef(input logic [31:0] x);
        longint lo, hi, mid;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(x)) lo = mid;
            else hi = mid - 1;
        end
        return lo[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock cycle: note issues for the isqrt stand-in, then drive this cycle's inputs.
    task automatic tick();
        @(negedge clk);
        if (!rst && bus.isqrt_x_vld) jobQ.push_back('{cyc + LAT, isqrtRef(bus.isqrt_x)});
        @(posedge clk);
        #2;
        cyc++;
        bus.req_x_vld = stimMask;
        for (int i = 0; i < NR; i++) if (stimMask[i]) bus.req_x[i] = stimX[i];
        if (autoRe) begin
            for (int i = 0; i < NR; i++) begin
                if (bus.req_y_vld[i]) begin
                    bus.req_x_vld[i] = 1'b1;
                    bus.req_x[i]     = $urandom;
                end
            end
        end
        stimMask        = '0;
        bus.isqrt_y_vld = 1'b0;
        if (jobQ.size() > 0 && jobQ[0].due == cyc) begin
            bus.isqrt_y_vld = 1'b1;
            bus.isqrt_y     = jobQ[0].y;
            void'(jobQ.pop_front());
        end else if (spurReq) begin
            bus.isqrt_y_vld = 1'b1;
            bus.isqrt_y     = 16'd7;
            spurReq         = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] mask, input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2);
        stimMask = mask;
        stimX[0] = a0;
        stimX[1] = a1;
        stimX[2] = a2;
        tick();
        lastStimCycle = cyc;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Phase model: each requester is idle, waiting for issue, or in flight; tags queue in issue order.
    initial begin
        int          mPhase[NR];
        logic [31:0] mArg[NR];
        logic [15:0] mY[NR];
        logic [2:0]  mYv;
        bit          mErr;
        int          mLast;
        int          mTags[$];
        bit          busyOld[NR];
        int          g, c, t;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < NR; i++) begin
                    mPhase[i] = IDLE;
                    mY[i]     = '0;
                    checkOutput($sformatf("rstReqY[%0d]", i), bus.req_y[i], 0);
                end
                mYv   = '0;
                mErr  = 1'b0;
                mLast = NR - 1;
                mTags.delete();
                checkOutput("rstReqYvld", bus.req_y_vld, 0);
                checkOutput("rstIsqrtXvld", bus.isqrt_x_vld, 0);
                checkOutput("rstErr", bus.err, 0);
            end else begin
                g = -1;
                if (mTags.size() < NR) begin
                    for (int k = 1; k <= NR; k++) begin
                        c = (mLast + k) % NR;
                        if (g < 0 && mPhase[c] == WAITING) g = c;
                    end
                end
                checkOutput("isqrtXvld", bus.isqrt_x_vld, (g >= 0) ? 1 : 0);
                if (g >= 0) checkOutput("isqrtX", bus.isqrt_x, mArg[g]);
                checkOutput("reqYvld", bus.req_y_vld, mYv);
                for (int i = 0; i < NR; i++) checkOutput($sformatf("reqY[%0d]", i), bus.req_y[i], mY[i]);
                checkOutput("err", bus.err, mErr);

                if (bus.isqrt_x_vld) issueLog.push_back('{cyc, bus.isqrt_x});
                for (int i = 0; i < NR; i++) if (bus.req_y_vld[i]) respLog.push_back('{cyc, i, bus.req_y[i]});

                for (int i = 0; i < NR; i++) busyOld[i] = (mPhase[i] != IDLE);
                mYv = '0;
                if (bus.isqrt_y_vld) begin
                    if (mTags.size() > 0) begin
                        t         = mTags.pop_front();
                        mYv[t]    = 1'b1;
                        mY[t]     = bus.isqrt_y;
                        mPhase[t] = IDLE;
                    end else begin
                        mErr = 1'b1;
                    end
                end
                if (g >= 0) begin
                    mPhase[g] = INFLIGHT;
                    mLast     = g;
                    mTags.push_back(g);
                end
                for (int i = 0; i < NR; i++) begin
                    if (bus.req_x_vld[i]) begin
                        if (busyOld[i]) mErr = 1'b1;
                        else begin
                            mPhase[i] = WAITING;
                            mArg[i]   = bus.req_x[i];
                        end
                    end
                end
            end
        end
    end

    initial begin
        int cnt[NR];
        int minC, maxC, c0;
        logic [31:0] expX[NR];
        rst             = 1'b1;
        bus.req_x_vld   = '0;
        bus.req_x       = '0;
        bus.isqrt_y_vld = 1'b0;
        bus.isqrt_y     = '0;
        stimMask        = '0;
        autoRe          = 1'b0;
        spurReq         = 1'b0;

        checkOutput("refSqrt144", isqrtRef(32'd144), 12);
        checkOutput("refSqrt143", isqrtRef(32'd143), 11);
        checkOutput("refSqrtMax", isqrtRef(32'hFFFF_FFFF), 65535);

        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] single request");
        issueLog.delete();
        respLog.delete();
        applyStimulus(3'b010, 0, 144, 0);
        c0 = lastStimCycle;
        repeat (10) tick();
        checkOutput("t1IssueCnt", issueLog.size(), 1);
        if (issueLog.size() >= 1) begin
            checkOutput("t1IssueCyc", issueLog[0].cycle, c0 + 1);
            checkOutput("t1IssueX", issueLog[0].x, 144);
        end
        checkOutput("t1RespCnt", respLog.size(), 1);
        if (respLog.size() >= 1) begin
            checkOutput("t1RespCyc", respLog[0].cycle, c0 + 6);
            checkOutput("t1RespIdx", respLog[0].idx, 1);
            checkOutput("t1RespY", respLog[0].y, 12);
        end

        $display("[TB] contention");
        doReset();
        issueLog.delete();
        respLog.delete();
        applyStimulus(3'b111, 1, 4, 9);
        c0 = lastStimCycle;
        repeat (12) tick();
        expX[0] = 1;
        expX[1] = 4;
        expX[2] = 9;
        checkOutput("t2IssueCnt", issueLog.size(), 3);
        checkOutput("t2RespCnt", respLog.size(), 3);
        for (int i = 0; i < NR; i++) begin
            if (issueLog.size() > i) begin
                checkOutput($sformatf("t2IssueX%0d", i), issueLog[i].x, expX[i]);
                checkOutput($sformatf("t2IssueCyc%0d", i), issueLog[i].cycle, c0 + 1 + i);
            end
            if (respLog.size() > i) begin
                checkOutput($sformatf("t2RespIdx%0d", i), respLog[i].idx, i);
                checkOutput($sformatf("t2RespY%0d", i), respLog[i].y, i + 1);
            end
        end

        $display("[TB] fairness");
        respLog.delete();
        autoRe = 1'b1;
        applyStimulus(3'b111, 100, 200, 300);
        repeat (299) tick();
        autoRe = 1'b0;
        repeat (15) tick();
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        foreach (respLog[k]) cnt[respLog[k].idx]++;
        minC = cnt[0];
        maxC = cnt[0];
        for (int i = 1; i < NR; i++) begin
            if (cnt[i] < minC) minC = cnt[i];
            if (cnt[i] > maxC) maxC = cnt[i];
        end
        checkOutput("t3FairSpread", (maxC - minC <= 1) ? 1 : 0, 1);
        checkOutput("t3Active", (minC >= 40) ? 1 : 0, 1);
        checkOutput("t3Err", bus.err, 0);

        $display("[TB] protocol error");
        doReset();
        respLog.delete();
        applyStimulus(3'b001, 49, 0, 0);
        applyStimulus(3'b001, 64, 0, 0);
        repeat (10) tick();
        checkOutput("t4Err", bus.err, 1);
        checkOutput("t4RespCnt", respLog.size(), 1);
        if (respLog.size() >= 1) begin
            checkOutput("t4RespIdx", respLog[0].idx, 0);
            checkOutput("t4RespY", respLog[0].y, 7);
        end

        $display("[TB] spurious response");
        doReset();
        issueLog.delete();
        respLog.delete();
        spurReq = 1'b1;
        repeat (5) tick();
        checkOutput("t5RespCnt", respLog.size(), 0);
        checkOutput("t5IssueCnt", issueLog.size(), 0);
        checkOutput("t5Err", bus.err, 1);

        $display("[TB] reset mid-flight");
        doReset();
        respLog.delete();
        applyStimulus(3'b011, 16, 81, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6ErrAfterRst", bus.err, 0);
        repeat (6) tick();
        checkOutput("t6LateRespCnt", respLog.size(), 0);
        checkOutput("t6Err", bus.err, 1);
        issueLog.delete();
        respLog.delete();
        applyStimulus(3'b011, 25, 100, 0);
        repeat (12) tick();
        checkOutput("t6IssueCnt", issueLog.size(), 2);
        if (issueLog.size() >= 1) checkOutput("t6FirstIssueX", issueLog[0].x, 25);
        checkOutput("t6RespCnt", respLog.size(), 2);
        if (respLog.size() >= 2) begin
            checkOutput("t6Resp0Idx", respLog[0].idx, 0);
            checkOutput("t6Resp0Y", respLog[0].y, 5);
            checkOutput("t6Resp1Idx", respLog[1].idx, 1);
            checkOutput("t6Resp1Y", respLog[1].y, 10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/isqrt_share_arbiter.md
ISQRT_SHARE_ARBITER -- requirements
Module: isqrt_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters (formula FSMs) sharing one isqrt instance; legal range 2..8.
REQ-002 Parameter TAG_DEPTH, default N_REQ: depth of the in-flight tag FIFO; SHALL be >= N_REQ.
REQ-003 clk  input  1  sole clock; all state on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_x_vld  input  N_REQ  per-requester single-cycle request pulse.
REQ-006 req_x  input  N_REQ x 32  per-requester isqrt argument, valid with req_x_vld[i].
REQ-007 req_y_vld  output  N_REQ  per-requester result pulse.
REQ-008 req_y  output  N_REQ x 16  per-requester result, valid with req_y_vld[i].
REQ-009 isqrt_x_vld  output  1  issue strobe to the shared isqrt.
REQ-010 isqrt_x  output  32  argument to the shared isqrt.
REQ-011 isqrt_y_vld  input  1  isqrt result strobe; results return in issue order, fixed or variable latency.
REQ-012 isqrt_y  input  16  isqrt result.
REQ-013 err  output  1  sticky protocol-error flag.

Function
REQ-014 Each requester SHALL have a one-entry holding register (pend[i], arg[i]); req_x_vld[i] with pend[i]=0 and out[i]=0 SHALL load arg[i]<=req_x[i] and set pend[i] at that edge.
REQ-015 A requester with pend[i]=1 or out[i]=1 (outstanding in isqrt) is busy; req_x_vld[i] while busy SHALL be ignored and SHALL set err.
REQ-016 Each cycle, if any pend[i]=1 and the tag FIFO is not full, the block SHALL grant exactly one requester, round-robin, starting search at last_grant+1 modulo N_REQ.
REQ-017 Grant SHALL drive isqrt_x_vld=1 and isqrt_x=arg[g] combinationally in the same cycle; at the edge: pend[g]<=0, out[g]<=1, last_grant<=g, push g into the tag FIFO.
REQ-018 With no grant, isqrt_x_vld SHALL be 0; isqrt_x is don't-care.
REQ-019 Minimum latency req_x_vld[i] -> isqrt_x_vld SHALL be 1 cycle; worst case N_REQ cycles under full contention.
REQ-020 On isqrt_y_vld with non-empty tag FIFO: pop tag t; at the next edge req_y_vld[t]<=1, req_y[t]<=isqrt_y, out[t]<=0; all other req_y_vld bits 0.
REQ-021 req_y_vld SHALL be registered single-cycle pulses; req_y[i] SHALL hold its last value between pulses.
REQ-022 isqrt_y_vld with empty tag FIFO SHALL drop the result and set err.
REQ-023 Push (grant) and pop (response) in the same cycle SHALL both take effect; occupancy unchanged.
REQ-024 A requester whose result pulses in cycle n MAY issue req_x_vld in cycle n and SHALL be accepted (out cleared at that edge).
REQ-025 isqrt_y is zero-extended nowhere inside; widths pass through unchanged.

Reset
REQ-026 rst SHALL asynchronously clear pend, out, tag FIFO pointers/count, req_y_vld, req_y, err, and set last_grant=N_REQ-1 (requester 0 first).
REQ-027 Results returning from isqrt after reset mid-operation SHALL be handled per REQ-022 (dropped, err set).
REQ-028 err SHALL clear only on rst.

Structure
REQ-029 Package isqrt_arb_pkg SHALL hold default N_REQ, result/argument width constants, and the requester-id typedef (width $clog2(N_REQ)).
REQ-030 The tag FIFO SHALL be a separate sub-module, isqrt_tag_fifo (parameterised width/depth, push/pop/full/empty); round-robin logic stays in the top.

Verification
REQ-031 Single: req 1 sends x=144 at cycle 0 -> isqrt_x_vld=1, isqrt_x=144 at cycle 1; model latency 4 -> req_y_vld[1]=1, req_y[1]=12 at cycle 6.
REQ-032 Contention: reqs 0,1,2 pulse together with 1, 4, 9 after reset -> issue order 0,1,2 in cycles 1,2,3; results 1,2,3 routed to 0,1,2.
REQ-033 Fairness: all requesters re-request immediately on result for 300 cycles -> grant counts differ by at most 1.
REQ-034 Protocol error: req 0 pulses twice before its result -> second ignored, err=1, exactly one result to req 0.
REQ-035 Spurious response: isqrt_y_vld with no issues -> no req_y_vld, err=1.
REQ-036 Reset mid-flight: rst for 1 cycle while 2 results outstanding -> all outputs cleared; late results dropped, err=1; next request served normally from requester 0 priority.
